// File: rtl/regfile_param.sv
// Parametrised register file with pending-result scoreboard,
// optional write-to-read bypass and optional hard-wired zero register.
module regfile_param #(
    parameter int DATA_W   = 8,
    parameter int NREGS    = 8,
    parameter int ADDR_W   = $clog2(NREGS),
    parameter int OVER_REG = NREGS - 1,
    parameter bit BYPASS   = 1'b1,
    parameter bit R0_ZERO  = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_W-1:0]       rs1_i,
    input  logic [ADDR_W-1:0]       rs2_i,
    input  logic [ADDR_W-1:0]       rd_i,
    output logic [DATA_W-1:0]       data1_o,
    output logic [DATA_W-1:0]       data2_o,
    output logic [DATA_W-1:0]       dataD_o,
    output logic                    busy1_o,
    output logic                    busy2_o,
    output logic                    busyD_o,
    input  logic                    we_i,
    input  logic [ADDR_W-1:0]       waddr_i,
    input  logic [DATA_W-1:0]       wdata_i,
    input  logic                    over_we_i,
    input  logic [DATA_W-1:0]       over_i,
    input  logic                    issue_i,
    input  logic [ADDR_W-1:0]       issue_addr_i,
    output logic [NREGS*DATA_W-1:0] regs_o
);

    localparam logic [ADDR_W-1:0] LP_OVER = ADDR_W'(OVER_REG);
    localparam logic [ADDR_W-1:0] LP_ZERO = '0;

    logic [DATA_W-1:0] r_regs [NREGS];
    logic [NREGS-1:0]  r_busy;
    logic              w_wr_main;
    logic              w_wr_over;

    assign w_wr_main = we_i && !(R0_ZERO && (waddr_i == LP_ZERO));
    assign w_wr_over = we_i && over_we_i
                     && !(R0_ZERO && (LP_OVER == LP_ZERO));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NREGS; k++) begin
                r_regs[k] <= '0;
            end
            r_busy <= '0;
        end else begin
            for (int k = 0; k < NREGS; k++) begin
                if (w_wr_over && (LP_OVER == ADDR_W'(k))) begin
                    r_regs[k] <= over_i;
                end else if (w_wr_main && (waddr_i == ADDR_W'(k))) begin
                    r_regs[k] <= wdata_i;
                end
            end
            // Issue beats clear: a new producer is already in flight.
            for (int k = 0; k < NREGS; k++) begin
                if (R0_ZERO && (k == 0)) begin
                    r_busy[k] <= 1'b0;
                end else if (issue_i && (issue_addr_i == ADDR_W'(k))) begin
                    r_busy[k] <= 1'b1;
                end else if (we_i && (waddr_i == ADDR_W'(k))) begin
                    r_busy[k] <= 1'b0;
                end
            end
        end
    end

    function automatic logic [DATA_W-1:0] f_read(
        input logic [ADDR_W-1:0] a
    );
        logic [DATA_W-1:0] v;
        if (R0_ZERO && (a == LP_ZERO)) begin
            v = '0;
        end else if (BYPASS && w_wr_over && (a == LP_OVER)) begin
            v = over_i;
        end else if (BYPASS && w_wr_main && (a == waddr_i)) begin
            v = wdata_i;
        end else begin
            v = r_regs[a];
        end
        return v;
    endfunction

    always_comb begin
        data1_o = f_read(rs1_i);
        data2_o = f_read(rs2_i);
        dataD_o = f_read(rd_i);
    end

    assign busy1_o = r_busy[rs1_i];
    assign busy2_o = r_busy[rs2_i];
    assign busyD_o = r_busy[rd_i];

    always_comb begin
        regs_o = '0;
        for (int k = 0; k < NREGS; k++) begin
            regs_o[k*DATA_W +: DATA_W] = r_regs[k];
        end
    end

endmodule

// File: tb/tb_regfile_param.sv
// Directed bench for regfile_param: default, no-bypass, zero-reg
// and 16x16 configurations driven side by side.
module tb_regfile_param;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] rs1, rs2, rd, waddr, issue_addr;
    logic [7:0] wdata, over;
    logic       we, over_we, issue;

    logic [7:0]  a_d1, a_d2, a_dD, n_d1, n_d2, n_dD, z_d1, z_d2, z_dD;
    logic        a_b1, a_b2, a_bD, n_b1, n_b2, n_bD, z_b1, z_b2, z_bD;
    logic [63:0] a_regs, n_regs, z_regs;

    logic [3:0]   w_rs1, w_waddr;
    logic [15:0]  w_wdata, w_over, w_d1, w_d2, w_dD;
    logic         w_we, w_over_we, w_b1, w_b2, w_bD;
    logic [255:0] w_regs;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    regfile_param u_dut (
        .clk(clk), .rst(rst), .rs1_i(rs1), .rs2_i(rs2), .rd_i(rd),
        .data1_o(a_d1), .data2_o(a_d2), .dataD_o(a_dD),
        .busy1_o(a_b1), .busy2_o(a_b2), .busyD_o(a_bD),
        .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
        .over_we_i(over_we), .over_i(over), .issue_i(issue),
        .issue_addr_i(issue_addr), .regs_o(a_regs)
    );

    regfile_param #(.BYPASS(1'b0)) u_nb (
        .clk(clk), .rst(rst), .rs1_i(rs1), .rs2_i(rs2), .rd_i(rd),
        .data1_o(n_d1), .data2_o(n_d2), .dataD_o(n_dD),
        .busy1_o(n_b1), .busy2_o(n_b2), .busyD_o(n_bD),
        .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
        .over_we_i(over_we), .over_i(over), .issue_i(issue),
        .issue_addr_i(issue_addr), .regs_o(n_regs)
    );

    regfile_param #(.R0_ZERO(1'b1)) u_z (
        .clk(clk), .rst(rst), .rs1_i(rs1), .rs2_i(rs2), .rd_i(rd),
        .data1_o(z_d1), .data2_o(z_d2), .dataD_o(z_dD),
        .busy1_o(z_b1), .busy2_o(z_b2), .busyD_o(z_bD),
        .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
        .over_we_i(over_we), .over_i(over), .issue_i(issue),
        .issue_addr_i(issue_addr), .regs_o(z_regs)
    );

    regfile_param #(.DATA_W(16), .NREGS(16)) u_w (
        .clk(clk), .rst(rst), .rs1_i(w_rs1), .rs2_i(4'd0), .rd_i(4'd0),
        .data1_o(w_d1), .data2_o(w_d2), .dataD_o(w_dD),
        .busy1_o(w_b1), .busy2_o(w_b2), .busyD_o(w_bD),
        .we_i(w_we), .waddr_i(w_waddr), .wdata_i(w_wdata),
        .over_we_i(w_over_we), .over_i(w_over), .issue_i(1'b0),
        .issue_addr_i(4'd0), .regs_o(w_regs)
    );

    task automatic idle();
        we = 0; over_we = 0; issue = 0;
        waddr = 0; wdata = 0; over = 0; issue_addr = 0;
    endtask

    task automatic test_reset();
        rst = 1; idle();
        rs1 = 0; rs2 = 0; rd = 0;
        w_rs1 = 0; w_we = 0; w_over_we = 0;
        w_waddr = 0; w_wdata = 0; w_over = 0;
        #12;
        for (int a = 0; a < 8; a++) begin
            rs1 = 3'(a); rs2 = 3'(a); rd = 3'(a);
            #1;
            n_total++;
            if ({a_d1, a_d2, a_dD, a_b1, a_b2, a_bD} !== 27'd0) begin
                $display("FAIL reset_read a=%0d got %h/%h/%h b=%b%b%b exp 0",
                         a, a_d1, a_d2, a_dD, a_b1, a_b2, a_bD);
            end else n_pass++;
        end
        n_total++;
        if ({a_regs, n_regs, z_regs} !== 192'd0 || w_regs !== 256'd0) begin
            $display("FAIL reset_regs got %h exp 0", a_regs);
        end else n_pass++;
        @(negedge clk); rst = 0;
    endtask

    task automatic test_bypass();
        @(negedge clk);
        we = 1; waddr = 3; wdata = 8'hA5; rs1 = 3; rs2 = 3; rd = 3;
        #1;
        n_total++;
        if (a_d1 !== 8'hA5) $display("FAIL bypass_same got %h exp a5", a_d1);
        else n_pass++;
        n_total++;
        if (n_d1 !== 8'h00) $display("FAIL nobypass_old got %h exp 00", n_d1);
        else n_pass++;
        n_total++;
        if (a_regs[31:24] !== 8'h00)
            $display("FAIL regs_no_bypass got %h exp 00", a_regs[31:24]);
        else n_pass++;
        @(posedge clk); #1; idle();
        #1;
        n_total++;
        if (a_d1 !== 8'hA5 || n_d1 !== 8'hA5)
            $display("FAIL write_after_edge got %h/%h exp a5", a_d1, n_d1);
        else n_pass++;
        n_total++;
        if (a_d2 !== 8'hA5 || a_dD !== 8'hA5 || a_regs[31:24] !== 8'hA5)
            $display("FAIL same_addr_ports got %h/%h/%h exp a5",
                     a_d2, a_dD, a_regs[31:24]);
        else n_pass++;
    endtask

    task automatic test_overflow();
        @(negedge clk);
        we = 1; over_we = 1; waddr = 7; wdata = 8'h11; over = 8'h22;
        rs1 = 7;
        #1;
        n_total++;
        if (a_d1 !== 8'h22) $display("FAIL over_bypass got %h exp 22", a_d1);
        else n_pass++;
        @(posedge clk); #1; idle();
        n_total++;
        if (a_regs[63:56] !== 8'h22 || n_regs[63:56] !== 8'h22)
            $display("FAIL over_wins got %h/%h exp 22",
                     a_regs[63:56], n_regs[63:56]);
        else n_pass++;
        @(negedge clk);
        we = 1; over_we = 1; waddr = 2; wdata = 8'h11; over = 8'h33;
        rs1 = 2; rs2 = 7;
        #1;
        n_total++;
        if (a_d1 !== 8'h11 || a_d2 !== 8'h33)
            $display("FAIL dual_bypass got %h/%h exp 11/33", a_d1, a_d2);
        else n_pass++;
        @(posedge clk); #1; idle();
        n_total++;
        if (a_regs[23:16] !== 8'h11 || a_regs[63:56] !== 8'h33)
            $display("FAIL dual_write got %h/%h exp 11/33",
                     a_regs[23:16], a_regs[63:56]);
        else n_pass++;
        @(negedge clk);
        over_we = 1; over = 8'h44;
        @(posedge clk); #1; idle();
        n_total++;
        if (a_regs[63:56] !== 8'h33 || n_d2 !== 8'h33)
            $display("FAIL over_no_we got %h/%h exp 33",
                     a_regs[63:56], n_d2);
        else n_pass++;
    endtask

    task automatic test_scoreboard();
        @(negedge clk);
        issue = 1; issue_addr = 5; rs1 = 5;
        #1;
        n_total++;
        if (a_b1 !== 1'b0) $display("FAIL busy_early got %b exp 0", a_b1);
        else n_pass++;
        @(posedge clk); #1; idle();
        n_total++;
        if (a_b1 !== 1'b1) $display("FAIL busy_set got %b exp 1", a_b1);
        else n_pass++;
        @(negedge clk);
        we = 1; waddr = 5; wdata = 8'h55;
        @(posedge clk); #1; idle();
        n_total++;
        if (a_b1 !== 1'b0 || a_d1 !== 8'h55)
            $display("FAIL busy_clear got %b/%h exp 0/55", a_b1, a_d1);
        else n_pass++;
        @(negedge clk);
        issue = 1; issue_addr = 5; we = 1; waddr = 5; wdata = 8'h66;
        @(posedge clk); #1; idle();
        n_total++;
        if (a_b1 !== 1'b1 || a_regs[47:40] !== 8'h66)
            $display("FAIL set_wins got %b/%h exp 1/66",
                     a_b1, a_regs[47:40]);
        else n_pass++;
        @(negedge clk);
        issue = 1; issue_addr = 5; over_we = 0;
        @(posedge clk); #1; idle();
        @(negedge clk);
        we = 1; over_we = 1; waddr = 1; over = 8'h77;
        @(posedge clk); #1; idle();
        n_total++;
        if (a_b1 !== 1'b1) $display("FAIL reissue_over got %b exp 1", a_b1);
        else n_pass++;
    endtask

    task automatic test_r0zero();
        @(negedge clk);
        we = 1; waddr = 0; wdata = 8'hFF; issue = 1; issue_addr = 0;
        rs1 = 0;
        #1;
        n_total++;
        if (z_d1 !== 8'h00 || a_d1 !== 8'hFF)
            $display("FAIL r0_bypass got %h/%h exp 00/ff", z_d1, a_d1);
        else n_pass++;
        @(posedge clk); #1; idle();
        n_total++;
        if (z_d1 !== 8'h00 || z_b1 !== 1'b0 || z_regs[7:0] !== 8'h00)
            $display("FAIL r0_zero got %h/%b/%h exp 00/0/00",
                     z_d1, z_b1, z_regs[7:0]);
        else n_pass++;
        n_total++;
        if (a_d1 !== 8'hFF || a_b1 !== 1'b1)
            $display("FAIL r0_normal got %h/%b exp ff/1", a_d1, a_b1);
        else n_pass++;
    endtask

    task automatic test_wide();
        @(negedge clk);
        w_we = 1; w_over_we = 1; w_waddr = 3;
        w_wdata = 16'h1234; w_over = 16'hBEEF; w_rs1 = 15;
        @(posedge clk); #1;
        w_we = 0; w_over_we = 0;
        n_total++;
        if (w_regs[255:240] !== 16'hBEEF || w_regs[63:48] !== 16'h1234)
            $display("FAIL wide_regs got %h/%h exp beef/1234",
                     w_regs[255:240], w_regs[63:48]);
        else n_pass++;
        n_total++;
        if (w_d1 !== 16'hBEEF) $display("FAIL wide_read got %h exp beef", w_d1);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        issue = 1; issue_addr = 6;
        @(posedge clk); #1; idle();
        @(negedge clk);
        rs1 = 4; rs2 = 6; we = 1; waddr = 4; wdata = 8'h77;
        #1; rst = 1; #1;
        n_total++;
        if (a_regs !== 64'd0 || n_d1 !== 8'h00 || a_b2 !== 1'b0)
            $display("FAIL async_clear got %h/%h/%b exp 0",
                     a_regs, n_d1, a_b2);
        else n_pass++;
        n_total++;
        if (a_d1 !== 8'h77) $display("FAIL reset_bypass got %h exp 77", a_d1);
        else n_pass++;
        @(posedge clk); #1; idle();
        @(negedge clk); rst = 0;
        @(posedge clk); #1;
        n_total++;
        if (a_d1 !== 8'h00 || a_regs[39:32] !== 8'h00)
            $display("FAIL write_lost got %h exp 00", a_d1);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_overflow();
        test_scoreboard();
        test_r0zero();
        test_wide();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
